// File: rtl/or_sweep_pkg.sv
// Shared types and limits for the reduction-OR sweep checker.
package or_sweep_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SWEEP,
        DRAIN,
        DONE
    } state_t;

    localparam int LAT_MAX = 8;

    // Delay-line entry is {valid, exp, vec[W-1:0]}; W is only known per instance.
    function automatic int entry_width(input int w);
        return w + 2;
    endfunction

endpackage

// File: rtl/or_sweep_delay.sv
// LAT-stage shift register of golden entries; collapses to a wire when LAT is 0.
module or_sweep_delay #(
    parameter int DW  = 12,
    parameter int LAT = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic [DW-1:0] d_i,
    output logic [DW-1:0] q_o
);

    generate
        if (LAT == 0) begin : g_wire
            logic unused_ok;
            assign unused_ok = ^{clk, rst, clr};
            assign q_o       = d_i;
        end else begin : g_pipe
            logic [DW-1:0] stage_q [LAT];
            for (genvar gi = 0; gi < LAT; gi++) begin : g_stage
                if (gi == 0) begin : g_head
                    always_ff @(posedge clk) begin
                        if (rst || clr) stage_q[gi] <= '0;
                        else            stage_q[gi] <= d_i;
                    end
                end else begin : g_body
                    always_ff @(posedge clk) begin
                        if (rst || clr) stage_q[gi] <= '0;
                        else            stage_q[gi] <= stage_q[gi-1];
                    end
                end
            end
            assign q_o = stage_q[LAT-1];
        end
    endgenerate

endmodule

// File: rtl/or_sweep_checker.sv
// Exhaustive stimulus/response checker for a W-input reduction-OR unit of latency LAT.
// Optional OR_SWEEP_STOP_ON_FAIL_EN: end the sweep on the first mismatch.
module or_sweep_checker
    import or_sweep_pkg::*;
#(
    parameter int W   = 10,
    parameter int LAT = 0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    output logic [W-1:0] vec_o,
    input  logic         dut_o,
    output logic         busy,
    output logic         done,
    output logic         pass,
    output logic [W:0]   err_count,
    output logic [W-1:0] first_fail_vec,
    output logic         first_fail_valid
);

    localparam int           EW         = entry_width(W);
    localparam int           CW         = $clog2(LAT_MAX + 1);
    localparam logic [W-1:0] VEC_LAST   = '1;
    localparam logic [CW-1:0] DRAIN_LOAD = CW'((LAT > 0) ? LAT - 1 : 0);

    typedef struct packed {
        logic         valid;
        logic         exp;
        logic [W-1:0] vec;
    } entry_t;

    state_t        state_q;
    logic [W-1:0]  vec_q;
    logic [W:0]    err_q;
    logic [W-1:0]  ffv_q;
    logic          ffvalid_q;
    logic          pass_q;
    logic          busy_q;
    logic          done_q;
    logic [CW-1:0] drain_cnt_q;

    entry_t        push_e;
    entry_t        tap_e;
    logic [EW-1:0] tap_bits;
    logic          mismatch;
    logic          capture;
    logic          stop_now;
    logic [W:0]    err_d;
    logic [W-1:0]  ffv_d;
    logic          ffvalid_d;

    always_comb begin
        push_e.valid = (state_q == SWEEP);
        push_e.exp   = |vec_q;
        push_e.vec   = vec_q;
    end

    or_sweep_delay #(
        .DW (EW),
        .LAT(LAT)
    ) u_delay (
        .clk(clk),
        .rst(rst),
        .clr(stop_now),
        .d_i(push_e),
        .q_o(tap_bits)
    );

    assign tap_e     = entry_t'(tap_bits);
    assign mismatch  = tap_e.valid && (dut_o != tap_e.exp);
    assign capture   = mismatch && !ffvalid_q;
    assign err_d     = err_q + (W+1)'(mismatch);
    assign ffv_d     = capture ? tap_e.vec : ffv_q;
    assign ffvalid_d = ffvalid_q | mismatch;

    // Stopping also flushes the delay line so stale entries cannot leak into a restart.
`ifdef OR_SWEEP_STOP_ON_FAIL_EN
    assign stop_now = capture;
`else
    assign stop_now = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            vec_q       <= '0;
            err_q       <= '0;
            ffv_q       <= '0;
            ffvalid_q   <= 1'b0;
            pass_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            drain_cnt_q <= '0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        state_q   <= SWEEP;
                        vec_q     <= '0;
                        err_q     <= '0;
                        ffv_q     <= '0;
                        ffvalid_q <= 1'b0;
                        pass_q    <= 1'b0;
                        busy_q    <= 1'b1;
                        done_q    <= 1'b0;
                    end
                end
                SWEEP: begin
                    err_q     <= err_d;
                    ffv_q     <= ffv_d;
                    ffvalid_q <= ffvalid_d;
                    if (stop_now) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        pass_q  <= 1'b0;
                    end else if (vec_q == VEC_LAST) begin
                        if (LAT > 0) begin
                            state_q     <= DRAIN;
                            drain_cnt_q <= DRAIN_LOAD;
                        end else begin
                            state_q <= DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            pass_q  <= (err_d == '0);
                        end
                    end else begin
                        vec_q <= vec_q + W'(1);
                    end
                end
                DRAIN: begin
                    err_q     <= err_d;
                    ffv_q     <= ffv_d;
                    ffvalid_q <= ffvalid_d;
                    if (stop_now || drain_cnt_q == '0) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        pass_q  <= !stop_now && (err_d == '0);
                    end else begin
                        drain_cnt_q <= drain_cnt_q - CW'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign vec_o            = vec_q;
    assign busy             = busy_q;
    assign done             = done_q;
    assign pass             = pass_q;
    assign err_count        = err_q;
    assign first_fail_vec   = ffv_q;
    assign first_fail_valid = ffvalid_q;

endmodule

// File: tb/tb_or_sweep_checker.sv
// Directed bench: W=10/LAT=0 and W=4/LAT=2 checkers driving behavioural OR units.
module tb_or_sweep_checker;

`ifdef OR_SWEEP_STOP_ON_FAIL_EN
    localparam bit STOP = 1'b1;
`else
    localparam bit STOP = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Instance A: W=10, LAT=0, combinational unit with selectable faults.
    logic        rst_a, start_a, dut_a, busy_a, done_a, pass_a, ffval_a;
    logic [9:0]  vec_a, ffv_a;
    logic [10:0] err_a;
    int          mode_a;

    always_comb begin
        case (mode_a)
            1:       dut_a = 1'b0;
            2:       dut_a = 1'b1;
            3:       dut_a = (vec_a == 10'd37) ? ~(|vec_a) : |vec_a;
            default: dut_a = |vec_a;
        endcase
    end

    or_sweep_checker #(.W(10), .LAT(0)) u_a (
        .clk(clk), .rst(rst_a), .start(start_a), .vec_o(vec_a), .dut_o(dut_a),
        .busy(busy_a), .done(done_a), .pass(pass_a), .err_count(err_a),
        .first_fail_vec(ffv_a), .first_fail_valid(ffval_a)
    );

    // Instance B: W=4, LAT=2, unit with two or one register stages.
    logic       rst_b, start_b, dut_b, busy_b, done_b, pass_b, ffval_b;
    logic [3:0] vec_b, ffv_b;
    logic [4:0] err_b;
    int         mode_b;
    logic       r1_b = 1'b0;
    logic       r2_b = 1'b0;

    always @(posedge clk) begin
        r1_b <= |vec_b;
        r2_b <= r1_b;
    end
    assign dut_b = (mode_b == 1) ? r1_b : r2_b;

    or_sweep_checker #(.W(4), .LAT(2)) u_b (
        .clk(clk), .rst(rst_b), .start(start_b), .vec_o(vec_b), .dut_o(dut_b),
        .busy(busy_b), .done(done_b), .pass(pass_b), .err_count(err_b),
        .first_fail_vec(ffv_b), .first_fail_valid(ffval_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Start on edge k; n = edges after k until done is seen (3000 means timeout).
    task automatic sweep_a(input int mid, output int n);
        @(negedge clk);
        start_a = 1'b1;
        @(posedge clk);
        #1;
        n = 0;
        while (done_a !== 1'b1 && n < 3000) begin
            start_a = (n == mid);
            @(posedge clk);
            #1;
            n++;
        end
        start_a = 1'b0;
        $display("sweep A mode=%0d edges=%0d err=%0d ffv=%0d pass=%0d vec=%0d",
                 mode_a, n, err_a, ffv_a, pass_a, vec_a);
    endtask

    task automatic sweep_b(output int n);
        @(negedge clk);
        start_b = 1'b1;
        @(posedge clk);
        #1;
        start_b = 1'b0;
        n = 0;
        while (done_b !== 1'b1 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        $display("sweep B mode=%0d edges=%0d err=%0d ffv=%0d pass=%0d vec=%0d",
                 mode_b, n, err_b, ffv_b, pass_b, vec_b);
    endtask

    initial begin
        int n;
        int m;
        rst_a = 1'b1; rst_b = 1'b1; start_a = 1'b0; start_b = 1'b0;
        mode_a = 0; mode_b = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_a = 1'b0; rst_b = 1'b0;
        #1;
        check("rst_vec",   32'(vec_a),   32'd0);
        check("rst_err",   32'(err_a),   32'd0);
        check("rst_busy",  32'(busy_a),  32'd0);
        check("rst_done",  32'(done_a),  32'd0);
        check("rst_pass",  32'(pass_a),  32'd0);
        check("rst_ffval", 32'(ffval_a), 32'd0);
        check("rst_b_done", 32'(done_b), 32'd0);

        // Ideal unit
        mode_a = 0;
        sweep_a(-1, n);
        check("ideal_edges", 32'(n),       32'd1024);
        check("ideal_pass",  32'(pass_a),  32'd1);
        check("ideal_err",   32'(err_a),   32'd0);
        check("ideal_ffval", 32'(ffval_a), 32'd0);
        check("ideal_vec",   32'(vec_a),   32'd1023);
        check("ideal_busy",  32'(busy_a),  32'd0);

        // Stuck-at-0: every nonzero vector fails
        mode_a = 1;
        sweep_a(-1, n);
        check("s0_edges", 32'(n),       STOP ? 32'd2 : 32'd1024);
        check("s0_err",   32'(err_a),   STOP ? 32'd1 : 32'd1023);
        check("s0_ffv",   32'(ffv_a),   32'd1);
        check("s0_ffval", 32'(ffval_a), 32'd1);
        check("s0_pass",  32'(pass_a),  32'd0);

        // Stuck-at-1: only vector 0 fails
        mode_a = 2;
        sweep_a(-1, n);
        check("s1_edges", 32'(n),     STOP ? 32'd1 : 32'd1024);
        check("s1_err",   32'(err_a), 32'd1);
        check("s1_ffv",   32'(ffv_a), 32'd0);
        check("s1_pass",  32'(pass_a), 32'd0);

        // LAT=2 with matching two-register unit
        mode_b = 0;
        sweep_b(n);
        check("b2_edges", 32'(n),      32'd18);
        check("b2_pass",  32'(pass_b), 32'd1);
        check("b2_err",   32'(err_b),  32'd0);
        check("b2_vec",   32'(vec_b),  32'd15);

        // LAT=2 with one-register unit: only the 0->1 transition disagrees
        mode_b = 1;
        sweep_b(n);
        check("b1_edges", 32'(n),      STOP ? 32'd3 : 32'd18);
        check("b1_err",   32'(err_b),  32'd1);
        check("b1_ffv",   32'(ffv_b),  32'd0);
        check("b1_pass",  32'(pass_b), 32'd0);
        check("b1_vec",   32'(vec_b),  STOP ? 32'd2 : 32'd15);

        // Reset mid-sweep at vec_o=500
        mode_a = 0;
        @(negedge clk);
        start_a = 1'b1;
        @(posedge clk);
        #1;
        start_a = 1'b0;
        m = 0;
        while (vec_a != 10'd500 && m < 2000) begin
            @(posedge clk);
            #1;
            m++;
        end
        check("mid_reach500", 32'(vec_a), 32'd500);
        check("mid_busy",     32'(busy_a), 32'd1);
        @(negedge clk);
        rst_a = 1'b1;
        @(posedge clk);
        #1;
        check("mrst_vec",   32'(vec_a),   32'd0);
        check("mrst_busy",  32'(busy_a),  32'd0);
        check("mrst_done",  32'(done_a),  32'd0);
        check("mrst_err",   32'(err_a),   32'd0);
        check("mrst_ffval", 32'(ffval_a), 32'd0);
        @(negedge clk);
        rst_a = 1'b0;

        // Fresh sweep with an ignored start pulse in the middle
        sweep_a(300, n);
        check("restart_edges", 32'(n),      32'd1024);
        check("restart_err",   32'(err_a),  32'd0);
        check("restart_pass",  32'(pass_a), 32'd1);

        // Unit wrong only for vector 37
        mode_a = 3;
        sweep_a(-1, n);
        check("v37_edges", 32'(n),       STOP ? 32'd38 : 32'd1024);
        check("v37_err",   32'(err_a),   32'd1);
        check("v37_ffv",   32'(ffv_a),   32'd37);
        check("v37_ffval", 32'(ffval_a), 32'd1);
        check("v37_pass",  32'(pass_a),  32'd0);
        check("v37_vec",   32'(vec_a),   STOP ? 32'd37 : 32'd1023);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/or_sweep_checker.md
Name: or_sweep_checker

Overview:
- Self-checking stimulus/response stage wrapped around a W-input reduction-OR unit.
- Upstream role: drives every W-bit vector 0 .. 2^W-1 into the unit, one per clock.
- Downstream role: consumes the unit's 1-bit output, compares it against a golden reduction-OR aligned to the unit latency, counts mismatches and captures the first failing vector.
- Synthesizable replacement for bench-only sweep logic; usable on hardware.

Parameters:
W, 10, vector width driven to the OR unit.
LAT, 0, unit latency in clock cycles from vec_o to dut_o; legal range 0..8.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  synchronous, active-high reset.
start  input  1  single-cycle pulse; begins a sweep when idle or done.
vec_o  output  W  vector presented to the OR unit.
dut_o  input  1  OR unit output, valid LAT cycles after the matching vec_o.
busy  output  1  high in SWEEP and DRAIN.
done  output  1  high in DONE.
pass  output  1  high in DONE when err_count == 0.
err_count  output  W+1  number of mismatches in the current/last sweep.
first_fail_vec  output  W  vector of the first mismatch.
first_fail_valid  output  1  first_fail_vec holds a captured value.

Behaviour:
- Clock/reset: one clock, clk. rst is synchronous and active-high.
- Reset values:
  - State IDLE.
  - vec_o, err_count, first_fail_vec = 0.
  - busy, done, pass, first_fail_valid = 0.
  - Delay line cleared; all valid bits 0.
- Reset mid-sweep aborts immediately to these values; no partial results are retained.
- FSM states: IDLE, SWEEP, DRAIN, DONE.
  - IDLE→SWEEP: start sampled high. Same edge loads vec_o=0 and clears err_count, first_fail_*, pass.
  - DONE→SWEEP: same as IDLE→SWEEP (restart).
  - SWEEP: vec_o increments by 1 every edge. The edge where vec_o == 2^W-1 is the last vector. On that edge go to DRAIN if LAT>0, else DONE. vec_o holds 2^W-1 afterwards; it does not wrap.
  - DRAIN: stays exactly LAT cycles, then DONE.
  - DONE: holds all results until start or rst.
  - start while busy is ignored.
- Golden path:
  - Each SWEEP cycle pushes {valid=1, exp=|vec_o, vec=vec_o} into an LAT-deep shift register.
  - Outside SWEEP, pushes valid=0.
  - With LAT=0 the tap is the current cycle's values, used directly.
- Check:
  - In any cycle where the tap is valid and dut_o != tap.exp, the next edge increments err_count.
  - On that edge, if first_fail_valid=0, capture first_fail_vec=tap.vec and set first_fail_valid=1.
- Widths:
  - err_count is W+1 bits, so it holds 2^W without overflow; no saturation logic is needed.
  - The vec_o compare for the last vector is an exact W-bit equality against all-ones.
- Timing: start sampled on edge k gives done=1 after edge k+2^W+LAT. pass is set on the same edge done rises.
- Invalid tap entries, including DRAIN pushes and IDLE, never count as errors.

Optional Feature:
- Macro: OR_SWEEP_STOP_ON_FAIL_EN.
- Defined: the first mismatch forces the next state to DONE on the same edge that captures it.
  - err_count=1, pass=0.
  - Remaining vectors are not driven; vec_o freezes at its current value.
- Undefined: the sweep always runs to completion and err_count is the total mismatch count.

Decomposition:
- Package or_sweep_pkg:
  - State enum (IDLE, SWEEP, DRAIN, DONE).
  - LAT_MAX=8.
  - Typedef for the delay-line entry {valid, exp, vec[W-1:0]}, parameterized by W through the module.
- Sub-module or_sweep_delay: parameterized LAT-stage shift register of entries. It is a pass-through wire when LAT=0 and is reset by rst.
- FSM, counters and capture logic stay in or_sweep_checker.

Test Plan:
1. W=10, LAT=0, ideal combinational OR; pulse start → after 1024 cycles done=1, pass=1, err_count=0, first_fail_valid=0, vec_o=1023.
2. W=10, LAT=0, DUT stuck-at-0 → err_count=1023, first_fail_vec=1, pass=0.
3. W=10, LAT=0, DUT stuck-at-1 → err_count=1, first_fail_vec=0, pass=0.
4. W=4, LAT=2, two-register OR → done exactly 18 cycles after start edge, pass=1. Same build with a one-register OR → err_count=1, first_fail_vec=0.
5. W=10, assert rst at vec_o=500 → next edge all outputs at reset values. A new start → full pass with err_count=0. Start pulsed mid-sweep is ignored (sweep length unchanged).
6. OR_SWEEP_STOP_ON_FAIL_EN defined, W=10, DUT wrong only for vector 37 → done one edge after vec_o=37 is checked, err_count=1, first_fail_vec=37, vec_o=37.
